// File: rtl/player_pkg.sv
// Shared definitions for the player core: opcodes, move directions,
// life-cycle states and instruction-word field helpers.
package player_pkg;

  localparam logic [3:0] OP_HPY = 4'd1;  // heal
  localparam logic [3:0] OP_DPY = 4'd2;  // damage
  localparam logic [3:0] OP_MOV = 4'd5;  // move
  localparam logic [3:0] OP_SHP = 4'd6;  // set hp

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_HURT  = 2'd1,
    ST_DEAD  = 2'd2
  } player_state_t;

  // Instruction word: [15:12] opcode, [11:4] operand, [3:0] unused.
  function automatic logic [3:0] instr_opcode(input logic [15:0] word);
    return word[15:12];
  endfunction

  function automatic logic [7:0] instr_operand(input logic [15:0] word);
    return word[11:4];
  endfunction

  // Move direction lives in the two low operand bits.
  function automatic logic [1:0] instr_dir(input logic [15:0] word);
    return word[5:4];
  endfunction

endpackage

// File: rtl/player_core_if.sv
// Instruction/status bundle between the game FSM (master) and the
// player core (slave); hp/posX/posY also feed the renderer.
interface player_core_if;
  logic        respawn;
  logic [15:0] playerInstruction;
  logic        isMove;
  logic        startDmg;
  logic [7:0]  hp;
  logic [7:0]  posX;
  logic [7:0]  posY;
  logic        isDeath;
  logic        invul;

  modport master (
    output respawn, playerInstruction, isMove, startDmg,
    input  hp, posX, posY, isDeath, invul
  );

  modport slave (
    input  respawn, playerInstruction, isMove, startDmg,
    output hp, posX, posY, isDeath, invul
  );
endinterface

// File: rtl/player_core_move_ticker.sv
// Move prescaler: while en is held, emits a one-cycle tick every DIV
// cycles; clr restarts the count, and cycles with neither en nor clr hold it.
module move_ticker #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_reg;

  // Tick on the edge where the count sits at its last value.
  assign tick = en && (cnt_reg == W'(DIV - 1));

  // Count enabled cycles, wrapping on each tick.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/player_core.sv
// Player core: executes the instruction stream from the game FSM,
// tracking HP, soul position in the dodge box and post-hit invulnerability.
module player_core
  import player_pkg::*;
#(
  parameter int HP_MAX    = 100,
  parameter int BOX_MIN_X = 0,
  parameter int BOX_MAX_X = 200,
  parameter int BOX_MIN_Y = 0,
  parameter int BOX_MAX_Y = 120,
  parameter int START_X   = 100,
  parameter int START_Y   = 60,
  parameter int STEP      = 2,
  parameter int MOVE_DIV  = 4,
  parameter int INVUL_CYC = 8
) (
  input  logic          clk,
  input  logic          reset,
  player_core_if.slave  bus
);
  localparam int IW = (INVUL_CYC > 1) ? $clog2(INVUL_CYC) : 1;

  localparam logic [7:0] HP_MAX8  = 8'(HP_MAX);
  localparam logic [7:0] START_X8 = 8'(START_X);
  localparam logic [7:0] START_Y8 = 8'(START_Y);
  localparam logic [7:0] MIN_X8   = 8'(BOX_MIN_X);
  localparam logic [7:0] MAX_X8   = 8'(BOX_MAX_X);
  localparam logic [7:0] MIN_Y8   = 8'(BOX_MIN_Y);
  localparam logic [7:0] MAX_Y8   = 8'(BOX_MAX_Y);
  localparam logic [8:0] STEP9    = 9'(STEP);

  player_state_t state_reg;
  logic [7:0]    hp_reg;
  logic [7:0]    pos_x_reg;
  logic [7:0]    pos_y_reg;
  logic [IW-1:0] invul_cnt_reg;
  logic          dead_reg;
  logic          invul_reg;

  logic [3:0] opcode;
  logic [7:0] operand;
  logic [1:0] dir;
  logic       unused_low_bits;

  assign opcode          = instr_opcode(bus.playerInstruction);
  assign operand         = instr_operand(bus.playerInstruction);
  assign dir             = instr_dir(bus.playerInstruction);
  assign unused_low_bits = ^bus.playerInstruction[3:0];

  // startDmg owns the instruction word, so a value op freezes the prescaler.
  logic move_en;
  logic move_clr;
  logic move_tick;

  assign move_en  = bus.isMove && !bus.startDmg && (opcode == OP_MOV);
  assign move_clr = !bus.isMove;

  move_ticker #(.DIV(MOVE_DIV)) u_move_ticker (
    .clk  (clk),
    .srst (reset || bus.respawn),
    .en   (move_en),
    .clr  (move_clr),
    .tick (move_tick)
  );

  logic [8:0] heal_sum;
  logic [7:0] heal_val;
  logic [7:0] dmg_val;
  logic [7:0] set_val;
  logic [7:0] next_x;
  logic [7:0] next_y;
  logic [8:0] x_wide;
  logic [8:0] y_wide;

  // Saturating HP arithmetic and clamped one-step position in 9 bits.
  always_comb begin
    heal_sum = {1'b0, hp_reg} + {1'b0, operand};
    heal_val = (heal_sum > {1'b0, HP_MAX8}) ? HP_MAX8 : heal_sum[7:0];
    dmg_val  = (operand >= hp_reg) ? 8'd0 : hp_reg - operand;
    set_val  = (operand > HP_MAX8) ? HP_MAX8 : operand;

    x_wide = {1'b0, pos_x_reg};
    y_wide = {1'b0, pos_y_reg};
    next_x = pos_x_reg;
    next_y = pos_y_reg;
    case (dir)
      DIR_UP:    next_y = (y_wide < {1'b0, MIN_Y8} + STEP9) ? MIN_Y8 : 8'(y_wide - STEP9);
      DIR_LEFT:  next_x = (x_wide < {1'b0, MIN_X8} + STEP9) ? MIN_X8 : 8'(x_wide - STEP9);
      DIR_DOWN:  next_y = (y_wide + STEP9 > {1'b0, MAX_Y8}) ? MAX_Y8 : 8'(y_wide + STEP9);
      default:   next_x = (x_wide + STEP9 > {1'b0, MAX_X8}) ? MAX_X8 : 8'(x_wide + STEP9);
    endcase
  end

  // Life-cycle FSM with registered HP, position and status flags.
  always_ff @(posedge clk) begin
    if (reset || bus.respawn) begin
      state_reg     <= ST_ALIVE;
      hp_reg        <= HP_MAX8;
      pos_x_reg     <= START_X8;
      pos_y_reg     <= START_Y8;
      invul_cnt_reg <= '0;
      dead_reg      <= 1'b0;
      invul_reg     <= 1'b0;
    end else if (state_reg != ST_DEAD) begin
      // Invulnerability window runs regardless of incoming ops.
      if (state_reg == ST_HURT) begin
        if (invul_cnt_reg == IW'(INVUL_CYC - 1)) begin
          state_reg <= ST_ALIVE;
          invul_reg <= 1'b0;
        end else begin
          invul_cnt_reg <= invul_cnt_reg + 1'b1;
        end
      end

      // Later assignments override the window bookkeeping above, so death wins.
      if (bus.startDmg) begin
        case (opcode)
          OP_HPY: hp_reg <= heal_val;
          OP_DPY: begin
            if (state_reg == ST_ALIVE) begin
              hp_reg <= dmg_val;
              if (dmg_val == 8'd0) begin
                state_reg <= ST_DEAD;
                dead_reg  <= 1'b1;
                invul_reg <= 1'b0;
              end else begin
                state_reg     <= ST_HURT;
                invul_reg     <= 1'b1;
                invul_cnt_reg <= '0;
              end
            end
          end
          OP_SHP: begin
            hp_reg <= set_val;
            if (set_val == 8'd0) begin
              state_reg <= ST_DEAD;
              dead_reg  <= 1'b1;
              invul_reg <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (move_tick) begin
        pos_x_reg <= next_x;
        pos_y_reg <= next_y;
      end
    end
  end

  assign bus.hp      = hp_reg;
  assign bus.posX    = pos_x_reg;
  assign bus.posY    = pos_y_reg;
  assign bus.isDeath = dead_reg;
  assign bus.invul   = invul_reg;
endmodule

// File: tb/tb_player_core.sv
// Bench for player_core: directed scenarios with hand-derived values plus
// a randomized run compared cycle by cycle against a behavioural model.
module tb_player_core;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  player_core_if bus_if ();

  player_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Behavioural model: HP, position, dead flag, cycles of invulnerability
  // left, and cycles the current move has been held since the last step.
  int m_hp, m_x, m_y, m_hurt_left, m_held;
  bit m_dead;

  function automatic void model_edge();
    int op, arg;
    bit step, was_hurt;
    op  = int'(bus_if.playerInstruction[15:12]);
    arg = int'(bus_if.playerInstruction[11:4]);
    if (reset || bus_if.respawn) begin
      m_hp = 100; m_x = 100; m_y = 60; m_dead = 0; m_hurt_left = 0; m_held = 0;
      return;
    end
    step = 0;
    if (!bus_if.isMove) m_held = 0;
    else if (!bus_if.startDmg && op == 5) begin
      m_held++;
      if (m_held == 4) begin m_held = 0; step = 1; end
    end
    if (m_dead) return;
    was_hurt = (m_hurt_left > 0);
    if (m_hurt_left > 0) m_hurt_left--;
    if (bus_if.startDmg) begin
      if (op == 1) m_hp = (m_hp + arg > 100) ? 100 : m_hp + arg;
      else if (op == 2 && !was_hurt) begin
        m_hp = (arg >= m_hp) ? 0 : m_hp - arg;
        if (m_hp == 0) begin m_dead = 1; m_hurt_left = 0; end
        else m_hurt_left = 8;
      end else if (op == 6) begin
        m_hp = (arg > 100) ? 100 : arg;
        if (m_hp == 0) begin m_dead = 1; m_hurt_left = 0; end
      end
    end else if (step) begin
      case (arg % 4)
        0: m_y = (m_y - 2 < 0) ? 0 : m_y - 2;
        1: m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
        2: m_y = (m_y + 2 > 120) ? 120 : m_y + 2;
        default: m_x = (m_x + 2 > 200) ? 200 : m_x + 2;
      endcase
    end
  endfunction

  // One clock edge; outputs are stable #1 later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0;
    bus_if.respawn = 0;
    bus_if.playerInstruction = 16'h0000;
    bus_if.isMove = 0;
    bus_if.startDmg = 0;
  endtask

  task automatic value_op(input logic [15:0] word);
    bus_if.playerInstruction = word;
    bus_if.startDmg = 1;
    cyc();
    bus_if.startDmg = 0;
    bus_if.playerInstruction = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    total++; if (bus_if.hp !== 8'd100) begin bad++; $display("FAIL reset_hp got=%0d want=100", bus_if.hp); end
    total++; if (bus_if.posX !== 8'd100 || bus_if.posY !== 8'd60) begin bad++; $display("FAIL reset_pos got=%0d/%0d want=100/60", bus_if.posX, bus_if.posY); end
    total++; if (bus_if.isDeath !== 1'b0 || bus_if.invul !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bus_if.isDeath, bus_if.invul); end
    $display("test_reset done hp=%0d pos=%0d/%0d", bus_if.hp, bus_if.posX, bus_if.posY);
  endtask

  task automatic test_move();
    bus_if.playerInstruction = 16'h5030;
    bus_if.isMove = 1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      total++;
      if (bus_if.posX !== 8'(100 + 2 * (c / 4))) begin
        bad++; $display("FAIL move_right cycle=%0d got=%0d want=%0d", c, bus_if.posX, 100 + 2 * (c / 4));
      end
    end
    bus_if.isMove = 0;
    cyc();
    $display("test_move done posX=%0d", bus_if.posX);
  endtask

  task automatic test_clamp();
    // 46 more steps from 106 reach 198.
    bus_if.playerInstruction = 16'h5030;
    bus_if.isMove = 1;
    repeat (184) cyc();
    total++; if (bus_if.posX !== 8'd198) begin bad++; $display("FAIL clamp_pre got=%0d want=198", bus_if.posX); end
    repeat (8) cyc();
    total++; if (bus_if.posX !== 8'd200) begin bad++; $display("FAIL clamp_right got=%0d want=200", bus_if.posX); end
    repeat (8) cyc();
    total++; if (bus_if.posX !== 8'd200) begin bad++; $display("FAIL clamp_right_hold got=%0d want=200", bus_if.posX); end
    bus_if.isMove = 0;
    cyc();
    bus_if.playerInstruction = 16'h5FC0;  // UP, high operand bits set
    bus_if.isMove = 1;
    repeat (120) cyc();
    total++; if (bus_if.posY !== 8'd0) begin bad++; $display("FAIL clamp_up got=%0d want=0", bus_if.posY); end
    repeat (8) cyc();
    total++; if (bus_if.posY !== 8'd0 || bus_if.posX !== 8'd200) begin bad++; $display("FAIL clamp_up_hold got=%0d/%0d want=200/0", bus_if.posX, bus_if.posY); end
    bus_if.isMove = 0;
    cyc();
    $display("test_clamp done pos=%0d/%0d", bus_if.posX, bus_if.posY);
  endtask

  task automatic test_damage();
    do_reset();
    value_op(16'h2140);
    total++; if (bus_if.hp !== 8'd80 || bus_if.invul !== 1'b1) begin bad++; $display("FAIL dmg_first got hp=%0d invul=%b want 80/1", bus_if.hp, bus_if.invul); end
    cyc(); cyc();
    value_op(16'h2140);
    total++; if (bus_if.hp !== 8'd80 || bus_if.invul !== 1'b1) begin bad++; $display("FAIL dmg_ignored got hp=%0d invul=%b want 80/1", bus_if.hp, bus_if.invul); end
    repeat (4) cyc();
    total++; if (bus_if.invul !== 1'b1) begin bad++; $display("FAIL invul_hold7 got=%b want=1", bus_if.invul); end
    cyc();
    total++; if (bus_if.invul !== 1'b0) begin bad++; $display("FAIL invul_drop8 got=%b want=0", bus_if.invul); end
    value_op(16'h2000);
    total++; if (bus_if.hp !== 8'd80 || bus_if.invul !== 1'b1) begin bad++; $display("FAIL dmg_zero got hp=%0d invul=%b want 80/1", bus_if.hp, bus_if.invul); end
    repeat (8) cyc();
    $display("test_damage done hp=%0d invul=%b", bus_if.hp, bus_if.invul);
  endtask

  task automatic test_heal();
    value_op(16'h65F0);
    total++; if (bus_if.hp !== 8'd95) begin bad++; $display("FAIL shp_95 got=%0d want=95", bus_if.hp); end
    value_op(16'h10A0);
    total++; if (bus_if.hp !== 8'd100) begin bad++; $display("FAIL hpy_sat got=%0d want=100", bus_if.hp); end
    value_op(16'h6320);
    value_op(16'h10A0);
    total++; if (bus_if.hp !== 8'd60) begin bad++; $display("FAIL hpy_plain got=%0d want=60", bus_if.hp); end
    value_op(16'h6FF0);
    total++; if (bus_if.hp !== 8'd100) begin bad++; $display("FAIL shp_sat got=%0d want=100", bus_if.hp); end
    $display("test_heal done hp=%0d", bus_if.hp);
  endtask

  task automatic test_death();
    value_op(16'h6050);
    value_op(16'h21E0);
    total++; if (bus_if.hp !== 8'd0 || bus_if.isDeath !== 1'b1 || bus_if.invul !== 1'b0) begin
      bad++; $display("FAIL death got hp=%0d dead=%b invul=%b want 0/1/0", bus_if.hp, bus_if.isDeath, bus_if.invul);
    end
    bus_if.playerInstruction = 16'h5010;
    bus_if.isMove = 1;
    repeat (8) cyc();
    bus_if.isMove = 0;
    value_op(16'h10A0);
    total++; if (bus_if.hp !== 8'd0 || bus_if.posX !== 8'd100 || bus_if.posY !== 8'd60 || bus_if.isDeath !== 1'b1) begin
      bad++; $display("FAIL dead_frozen got hp=%0d pos=%0d/%0d dead=%b want 0 100/60 1", bus_if.hp, bus_if.posX, bus_if.posY, bus_if.isDeath);
    end
    bus_if.respawn = 1;
    cyc();
    bus_if.respawn = 0;
    total++; if (bus_if.hp !== 8'd100 || bus_if.posX !== 8'd100 || bus_if.posY !== 8'd60 || bus_if.isDeath !== 1'b0) begin
      bad++; $display("FAIL respawn got hp=%0d pos=%0d/%0d dead=%b want 100 100/60 0", bus_if.hp, bus_if.posX, bus_if.posY, bus_if.isDeath);
    end
    $display("test_death done hp=%0d dead=%b", bus_if.hp, bus_if.isDeath);
  endtask

  task automatic test_reset_mid();
    value_op(16'h20A0);
    bus_if.playerInstruction = 16'h5030;
    bus_if.isMove = 1;
    cyc(); cyc();
    reset = 1;
    cyc();
    total++; if (bus_if.hp !== 8'd100 || bus_if.invul !== 1'b0 || bus_if.posX !== 8'd100) begin
      bad++; $display("FAIL reset_mid got hp=%0d invul=%b posX=%0d want 100/0/100", bus_if.hp, bus_if.invul, bus_if.posX);
    end
    reset = 0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      total++;
      if (bus_if.posX !== ((c == 4) ? 8'd102 : 8'd100)) begin
        bad++; $display("FAIL reset_mid_step cycle=%0d got=%0d want=%0d", c, bus_if.posX, (c == 4) ? 102 : 100);
      end
    end
    bus_if.isMove = 0;
    cyc();
    $display("test_reset_mid done posX=%0d", bus_if.posX);
  endtask

  task automatic test_random();
    logic [3:0] ops [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3};
    logic [3:0] op;
    logic [7:0] arg;
    int mism = 0;
    idle_inputs();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      op  = ops[$urandom_range(0, 4)];
      arg = 8'($urandom);
      if (op == 4'd2) arg = 8'($urandom_range(0, 40));
      if (op == 4'd6 && $urandom_range(0, 5) == 0) arg = 8'd0;
      bus_if.playerInstruction = {op, arg, 4'($urandom)};
      bus_if.isMove   = ($urandom_range(0, 3) != 0);
      bus_if.startDmg = ($urandom_range(0, 5) == 0);
      bus_if.respawn  = ($urandom_range(0, 60) == 0);
      reset           = ($urandom_range(0, 150) == 0);
      cyc();
      total++;
      if (bus_if.hp !== 8'(m_hp) || bus_if.posX !== 8'(m_x) || bus_if.posY !== 8'(m_y) ||
          bus_if.isDeath !== m_dead || bus_if.invul !== (m_hurt_left > 0)) begin
        bad++; mism++;
        $display("FAIL random cycle=%0d got hp=%0d pos=%0d/%0d dead=%b invul=%b want hp=%0d pos=%0d/%0d dead=%b invul=%b",
                 c, bus_if.hp, bus_if.posX, bus_if.posY, bus_if.isDeath, bus_if.invul,
                 m_hp, m_x, m_y, m_dead, m_hurt_left > 0);
      end
    end
    idle_inputs();
    $display("test_random done cycles=600 mismatched=%0d", mism);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    m_hp = 0; m_x = 0; m_y = 0; m_dead = 0; m_hurt_left = 0; m_held = 0;
    test_reset();
    test_move();
    test_clamp();
    test_damage();
    test_heal();
    test_death();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
